// File: rtl/seg7_pkg.sv
// Shared types, glyph table and pin-polarity helper for the 7-segment scanner.
package seg7_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-high

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t HEX_TO_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // Maps an active-high pattern to the pin level; callers truncate to their width.
  function automatic logic [15:0] drive_level(input logic [15:0] active_high,
                                              input bit          active_low);
    return active_low ? ~active_high : active_high;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running modulo-MOD counter with a combinational pulse on its last count.
module seg7_tick_gen #(
  parameter int unsigned MOD = 50000,
  parameter int unsigned W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  always_comb begin
    wrap = (cnt == W'(MOD - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nexys_7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver with blanking, PWM brightness and polarity control.
// Optional blinking per digit is built when SEG7_BLINK_EN is defined.
module nexys_7seg_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS         = 8,
  parameter int unsigned CLKS_PER_DIGIT     = 50000,
  parameter int unsigned BLANK_CLKS         = 500,
  parameter bit          ANODE_ACTIVE_LOW   = 1'b1,
  parameter bit          CATHODE_ACTIVE_LOW = 1'b1
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES       = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  seg_t                  seg_in [NUM_DIGITS],
  input  logic [NUM_DIGITS-1:0] hex_mode,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [3:0]            brightness,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [6:0]            cathodes,
  output logic                  dp
);

  localparam int unsigned CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned SPAN  = CLKS_PER_DIGIT - BLANK_CLKS;

  typedef logic [CNT_W:0] len_t;

  localparam len_t                  BLANK_LEN = len_t'(BLANK_CLKS);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = NUM_DIGITS'(drive_level(16'h0000, ANODE_ACTIVE_LOW));
  localparam logic [6:0]            CATH_OFF  = 7'(drive_level(16'h0000, CATHODE_ACTIVE_LOW));
  localparam logic                  DP_OFF    = 1'(drive_level(16'h0000, CATHODE_ACTIVE_LOW));

  if (BLANK_CLKS >= CLKS_PER_DIGIT) begin : g_bad_blank
    $error("nexys_7seg_mux: BLANK_CLKS must be less than CLKS_PER_DIGIT");
  end
  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("nexys_7seg_mux: NUM_DIGITS must be at least 2");
  end

  function automatic len_t on_len_for(input logic [3:0] b);
    if (b == 4'hF) begin
      return len_t'(SPAN);
    end
    return len_t'((SPAN * 32'(b)) >> 4);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [IDX_W-1:0] idx;

  seg7_tick_gen #(
    .MOD (CLKS_PER_DIGIT),
    .W   (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (wrap) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  logic blink_dark;

`ifdef SEG7_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FR_W-1:0] frame_cnt;
  logic            blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (wrap && (idx == LAST_IDX)) begin
      if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    blink_dark = blink_mask[idx] && !blink_on;
  end
`else
  always_comb begin
    blink_dark = 1'b0;
  end
`endif

  seg_t slot_seg;
  logic slot_dp;
  logic slot_en;
  len_t slot_len;

  seg_t cur_seg;
  logic cur_dp;
  logic cur_en;
  len_t cur_len;
  len_t cnt_ext;
  logic lit;
  logic [NUM_DIGITS-1:0] anode_hi;

  // On the slot's first cycle the slot registers are still being loaded, so
  // the live inputs are used directly; this keeps BLANK_CLKS == 0 correct.
  always_comb begin
    cur_seg = slot_seg;
    cur_dp  = slot_dp;
    cur_en  = slot_en;
    cur_len = slot_len;
    if (cnt == '0) begin
      cur_seg = hex_mode[idx] ? HEX_TO_SEG[seg_in[idx][3:0]] : seg_in[idx];
      cur_dp  = dp_in[idx];
      cur_en  = digit_en[idx] && !blink_dark;
      cur_len = on_len_for(brightness);
    end
    cnt_ext  = {1'b0, cnt};
    lit      = cur_en && (cnt_ext >= BLANK_LEN) && (cnt_ext < BLANK_LEN + cur_len);
    anode_hi = '0;
    if (lit) begin
      anode_hi[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_seg <= SEG_BLANK;
      slot_dp  <= 1'b0;
      slot_en  <= 1'b0;
      slot_len <= '0;
    end else if (cnt == '0) begin
      slot_seg <= cur_seg;
      slot_dp  <= cur_dp;
      slot_en  <= cur_en;
      slot_len <= cur_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= ANODE_OFF;
      cathodes <= CATH_OFF;
      dp       <= DP_OFF;
    end else begin
      anodes   <= NUM_DIGITS'(drive_level(16'(anode_hi), ANODE_ACTIVE_LOW));
      cathodes <= 7'(drive_level(16'(lit ? cur_seg : SEG_BLANK), CATHODE_ACTIVE_LOW));
      dp       <= 1'(drive_level(16'(lit && cur_dp), CATHODE_ACTIVE_LOW));
    end
  end

endmodule
